// File: rtl/gerenciador_slots_pkg.sv
// Shared definitions for the slot manager: opcodes, FSM states and width helpers.
package gerenciador_slots_pkg;

  localparam logic OP_ATUALIZAR = 1'b0;
  localparam logic OP_DESATIVAR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARAR  = 2'd1,
    ST_RESPONDER = 2'd2
  } estado_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/codificador_prioridade.sv
// Lowest-index priority encoder: returns the index of the lowest set bit and a found flag.
module codificador_prioridade #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] vetor,
  output logic [IDX_W-1:0] idx,
  output logic             encontrado
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx        = '0;
    encontrado = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vetor[i]) begin
        idx        = IDX_W'(i);
        encontrado = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gerenciador_slots.sv
// Slot manager: associative address table with lookup-or-allocate and release requests.
// Optional per-slot aging is compiled in with the macro GERENCIADOR_SLOTS_AGING_EN.
module gerenciador_slots
  import gerenciador_slots_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned ADR_WIDTH = 5,
  parameter int unsigned AGE_WIDTH = 8,
  localparam int unsigned IDX_W = idx_w(NUM_SLOTS),
  localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic                 req_op_in,
  input  logic [ADR_WIDTH-1:0] req_endereco_in,
  input  logic                 flush_in,
  output logic                 resp_valid_out,
  output logic [NUM_SLOTS-1:0] resp_habilitar_out,
  output logic [IDX_W-1:0]     resp_idx_out,
  output logic                 resp_hit_out,
  output logic                 resp_fail_out,
  output logic [NUM_SLOTS-1:0] slot_ativo_out,
  output logic [CNT_W-1:0]     ocupacao_out,
  output logic                 cheio_out,
  output logic                 vazio_out,
  output logic                 expirou_valid_out,
  output logic [IDX_W-1:0]     expirou_idx_out
);

  if (NUM_SLOTS < 2 || NUM_SLOTS > 64) begin : g_chk_slots
    $error("NUM_SLOTS must be in 2..64");
  end
  if (AGE_WIDTH < 1) begin : g_chk_age
    $error("AGE_WIDTH must be at least 1");
  end

  estado_t                estado_q;
  logic                   op_q;
  logic [ADR_WIDTH-1:0]   adr_q;
  logic [NUM_SLOTS-1:0]   valido_q;
  logic [ADR_WIDTH-1:0]   endereco_q [NUM_SLOTS];
  logic [CNT_W-1:0]       ocupacao_q;
  logic                   resp_valid_q;
  logic                   resp_hit_q;
  logic                   resp_fail_q;
  logic [NUM_SLOTS-1:0]   resp_habilitar_q;
  logic [IDX_W-1:0]       resp_idx_q;

  logic [NUM_SLOTS-1:0]   hit_vec;
  logic [IDX_W-1:0]       hit_idx;
  logic                   hit_found;
  logic [IDX_W-1:0]       livre_idx;
  logic                   livre_found;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_vec[i] = valido_q[i] && (endereco_q[i] == adr_q);
    end
  end

  codificador_prioridade #(
    .WIDTH (NUM_SLOTS),
    .IDX_W (IDX_W)
  ) u_enc_hit (
    .vetor      (hit_vec),
    .idx        (hit_idx),
    .encontrado (hit_found)
  );

  codificador_prioridade #(
    .WIDTH (NUM_SLOTS),
    .IDX_W (IDX_W)
  ) u_enc_livre (
    .vetor      (~valido_q),
    .idx        (livre_idx),
    .encontrado (livre_found)
  );

`ifdef GERENCIADOR_SLOTS_AGING_EN
  logic [AGE_WIDTH-1:0]   idade_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   expira_vec;
  logic [IDX_W-1:0]       expira_idx;
  logic                   expira_found;
  logic                   expirou_valid_q;
  logic [IDX_W-1:0]       expirou_idx_q;

  always_comb begin
    expira_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      expira_vec[i] = valido_q[i] && (&idade_q[i]);
    end
  end

  codificador_prioridade #(
    .WIDTH (NUM_SLOTS),
    .IDX_W (IDX_W)
  ) u_enc_expira (
    .vetor      (expira_vec),
    .idx        (expira_idx),
    .encontrado (expira_found)
  );

  assign expirou_valid_out = expirou_valid_q;
  assign expirou_idx_out   = expirou_idx_q;
`else
  assign expirou_valid_out = 1'b0;
  assign expirou_idx_out   = '0;
`endif

  // Comparison and table update share the edge leaving ST_COMPARAR, so the table state
  // seen during the response pulse already reflects the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q         <= ST_IDLE;
      op_q             <= OP_ATUALIZAR;
      adr_q            <= '0;
      valido_q         <= '0;
      ocupacao_q       <= '0;
      resp_valid_q     <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_fail_q      <= 1'b0;
      resp_habilitar_q <= '0;
      resp_idx_q       <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) endereco_q[i] <= '0;
`ifdef GERENCIADOR_SLOTS_AGING_EN
      for (int i = 0; i < NUM_SLOTS; i++) idade_q[i] <= '0;
      expirou_valid_q <= 1'b0;
      expirou_idx_q   <= '0;
`endif
    end else begin
      resp_valid_q     <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_fail_q      <= 1'b0;
      resp_habilitar_q <= '0;
      resp_idx_q       <= '0;
`ifdef GERENCIADOR_SLOTS_AGING_EN
      expirou_valid_q <= 1'b0;
      expirou_idx_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (valido_q[i] && !(&idade_q[i])) idade_q[i] <= idade_q[i] + 1'b1;
      end
`endif
      if (flush_in) begin
        estado_q   <= ST_IDLE;
        valido_q   <= '0;
        ocupacao_q <= '0;
      end else begin
        unique case (estado_q)
          ST_IDLE: begin
            if (req_valid_in) begin
              op_q     <= req_op_in;
              adr_q    <= req_endereco_in;
              estado_q <= ST_COMPARAR;
            end
`ifdef GERENCIADOR_SLOTS_AGING_EN
            if (expira_found) begin
              valido_q[expira_idx] <= 1'b0;
              if (ocupacao_q != '0) ocupacao_q <= ocupacao_q - 1'b1;
              expirou_valid_q <= 1'b1;
              expirou_idx_q   <= expira_idx;
            end
`endif
          end
          ST_COMPARAR: begin
            estado_q     <= ST_RESPONDER;
            resp_valid_q <= 1'b1;
            if (op_q == OP_ATUALIZAR) begin
              if (hit_found) begin
                resp_hit_q       <= 1'b1;
                resp_habilitar_q <= hit_vec;
                resp_idx_q       <= hit_idx;
`ifdef GERENCIADOR_SLOTS_AGING_EN
                idade_q[hit_idx] <= '0;
`endif
              end else if (livre_found) begin
                resp_habilitar_q      <= NUM_SLOTS'(1) << livre_idx;
                resp_idx_q            <= livre_idx;
                valido_q[livre_idx]   <= 1'b1;
                endereco_q[livre_idx] <= adr_q;
                if (ocupacao_q != CNT_W'(NUM_SLOTS)) ocupacao_q <= ocupacao_q + 1'b1;
`ifdef GERENCIADOR_SLOTS_AGING_EN
                idade_q[livre_idx] <= '0;
`endif
              end else begin
                resp_fail_q <= 1'b1;
              end
            end else if (hit_found) begin
              resp_hit_q        <= 1'b1;
              resp_habilitar_q  <= hit_vec;
              resp_idx_q        <= hit_idx;
              valido_q[hit_idx] <= 1'b0;
              if (ocupacao_q != '0) ocupacao_q <= ocupacao_q - 1'b1;
            end
          end
          ST_RESPONDER: estado_q <= ST_IDLE;
          default:      estado_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_ready_out      = (estado_q == ST_IDLE) && !flush_in;
  assign resp_valid_out     = resp_valid_q;
  assign resp_hit_out       = resp_hit_q;
  assign resp_fail_out      = resp_fail_q;
  assign resp_habilitar_out = resp_habilitar_q;
  assign resp_idx_out       = resp_idx_q;
  assign slot_ativo_out     = valido_q;
  assign ocupacao_out       = ocupacao_q;
  assign cheio_out          = (ocupacao_q == CNT_W'(NUM_SLOTS));
  assign vazio_out          = (ocupacao_q == '0);

endmodule

// File: tb/tb_gerenciador_slots.sv
// Directed bench for gerenciador_slots; aging scenario runs when GERENCIADOR_SLOTS_AGING_EN is set.
module tb_gerenciador_slots;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid_in = 1'b0;
  logic       req_ready_out;
  logic       req_op_in = 1'b0;
  logic [4:0] req_endereco_in = '0;
  logic       flush_in = 1'b0;
  logic       resp_valid_out;
  logic [7:0] resp_habilitar_out;
  logic [2:0] resp_idx_out;
  logic       resp_hit_out;
  logic       resp_fail_out;
  logic [7:0] slot_ativo_out;
  logic [3:0] ocupacao_out;
  logic       cheio_out;
  logic       vazio_out;
  logic       expirou_valid_out;
  logic [2:0] expirou_idx_out;

  int n_cmp = 0;
  int n_fail = 0;

  logic       got_valid, got_hit, got_fail, got_cheio, got_vazio;
  logic [7:0] got_hab, got_ativo;
  logic [2:0] got_idx;
  logic [3:0] got_ocup;
  int         lat;

  gerenciador_slots #(
    .NUM_SLOTS (8),
    .ADR_WIDTH (5),
    .AGE_WIDTH (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid_in       (req_valid_in),
    .req_ready_out      (req_ready_out),
    .req_op_in          (req_op_in),
    .req_endereco_in    (req_endereco_in),
    .flush_in           (flush_in),
    .resp_valid_out     (resp_valid_out),
    .resp_habilitar_out (resp_habilitar_out),
    .resp_idx_out       (resp_idx_out),
    .resp_hit_out       (resp_hit_out),
    .resp_fail_out      (resp_fail_out),
    .slot_ativo_out     (slot_ativo_out),
    .ocupacao_out       (ocupacao_out),
    .cheio_out          (cheio_out),
    .vazio_out          (vazio_out),
    .expirou_valid_out  (expirou_valid_out),
    .expirou_idx_out    (expirou_idx_out)
  );

  always #5 clk = ~clk;

  // Issue one request and capture the response pulse (at most 5 cycles after acceptance).
  task automatic do_req(input logic op, input logic [4:0] adr);
    int k;
    got_valid = 1'b0; got_hit = 1'b0; got_fail = 1'b0; got_hab = '0; got_idx = '0;
    got_ocup = '0; got_ativo = '0; got_cheio = 1'b0; got_vazio = 1'b0; lat = 0;
    k = 0;
    @(negedge clk);
    while (!req_ready_out && k < 20) begin
      @(negedge clk);
      k++;
    end
    req_valid_in = 1'b1; req_op_in = op; req_endereco_in = adr;
    @(posedge clk);
    #1 req_valid_in = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (resp_valid_out) begin
        got_valid = 1'b1; got_hit = resp_hit_out; got_fail = resp_fail_out;
        got_hab = resp_habilitar_out; got_idx = resp_idx_out; got_ocup = ocupacao_out;
        got_ativo = slot_ativo_out; got_cheio = cheio_out; got_vazio = vazio_out; lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (ocupacao_out !== 4'd0) begin n_fail++; $display("FAIL reset_ocup got %0d want 0", ocupacao_out); end
    n_cmp++; if (vazio_out !== 1'b1) begin n_fail++; $display("FAIL reset_vazio got %b want 1", vazio_out); end
    n_cmp++; if (cheio_out !== 1'b0) begin n_fail++; $display("FAIL reset_cheio got %b want 0", cheio_out); end
    n_cmp++; if (slot_ativo_out !== 8'h00) begin n_fail++; $display("FAIL reset_ativo got %h want 00", slot_ativo_out); end
    n_cmp++; if ({resp_valid_out, resp_hit_out, resp_fail_out, resp_habilitar_out, resp_idx_out, expirou_valid_out} !== '0) begin
      n_fail++; $display("FAIL reset_resp got nonzero response outputs want 0"); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready_out); end
  endtask

  task automatic test_atualizar_alloc();
    do_req(1'b0, 5'h05);
    n_cmp++; if (got_valid !== 1'b1) begin n_fail++; $display("FAIL alloc_valid got %b want 1", got_valid); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL alloc_latency got %0d want 2", lat); end
    n_cmp++; if (got_hit !== 1'b0) begin n_fail++; $display("FAIL alloc_hit got %b want 0", got_hit); end
    n_cmp++; if (got_idx !== 3'd0) begin n_fail++; $display("FAIL alloc_idx got %0d want 0", got_idx); end
    n_cmp++; if (got_hab !== 8'h01) begin n_fail++; $display("FAIL alloc_hab got %h want 01", got_hab); end
    n_cmp++; if (got_ocup !== 4'd1) begin n_fail++; $display("FAIL alloc_ocup got %0d want 1", got_ocup); end
    @(negedge clk);
    n_cmp++; if ({resp_valid_out, resp_habilitar_out, resp_idx_out, resp_hit_out, resp_fail_out} !== '0) begin
      n_fail++; $display("FAIL alloc_pulse_end got nonzero outputs want 0"); end
  endtask

  task automatic test_hit_release();
    do_req(1'b0, 5'h05);
    n_cmp++; if (got_hit !== 1'b1) begin n_fail++; $display("FAIL rehit_hit got %b want 1", got_hit); end
    n_cmp++; if (got_idx !== 3'd0) begin n_fail++; $display("FAIL rehit_idx got %0d want 0", got_idx); end
    n_cmp++; if (got_ocup !== 4'd1) begin n_fail++; $display("FAIL rehit_ocup got %0d want 1", got_ocup); end
    do_req(1'b1, 5'h05);
    n_cmp++; if (got_hit !== 1'b1) begin n_fail++; $display("FAIL release_hit got %b want 1", got_hit); end
    n_cmp++; if (got_hab !== 8'h01) begin n_fail++; $display("FAIL release_hab got %h want 01", got_hab); end
    n_cmp++; if (got_ativo !== 8'h00) begin n_fail++; $display("FAIL release_ativo got %h want 00", got_ativo); end
    n_cmp++; if (got_vazio !== 1'b1) begin n_fail++; $display("FAIL release_vazio got %b want 1", got_vazio); end
  endtask

  task automatic test_full();
    logic [7:0] exp_hab;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 5'h10 + 5'(i));
      exp_hab = 8'h01 << i;
      n_cmp++; if (got_idx !== 3'(i) || got_hab !== exp_hab || got_hit !== 1'b0) begin
        n_fail++; $display("FAIL fill_%0d got idx %0d hab %h hit %b want idx %0d hab %h hit 0", i, got_idx, got_hab, got_hit, i, exp_hab); end
    end
    do_req(1'b0, 5'h1F);
    n_cmp++; if (got_fail !== 1'b1) begin n_fail++; $display("FAIL full_fail got %b want 1", got_fail); end
    n_cmp++; if (got_hab !== 8'h00 || got_idx !== 3'd0) begin n_fail++; $display("FAIL full_hab got %h idx %0d want 00 idx 0", got_hab, got_idx); end
    n_cmp++; if (got_cheio !== 1'b1 || got_ocup !== 4'd8) begin n_fail++; $display("FAIL full_cheio got %b ocup %0d want 1 ocup 8", got_cheio, got_ocup); end
    do_req(1'b1, 5'h13);
    n_cmp++; if (got_hit !== 1'b1 || got_idx !== 3'd3) begin n_fail++; $display("FAIL full_release got hit %b idx %0d want 1 idx 3", got_hit, got_idx); end
    do_req(1'b0, 5'h1F);
    n_cmp++; if (got_idx !== 3'd3 || got_hab !== 8'h08 || got_fail !== 1'b0) begin
      n_fail++; $display("FAIL full_refill got idx %0d hab %h fail %b want idx 3 hab 08 fail 0", got_idx, got_hab, got_fail); end
  endtask

  task automatic test_desativar_miss();
    do_req(1'b1, 5'h0A);
    n_cmp++; if (got_valid !== 1'b1 || got_hit !== 1'b0 || got_fail !== 1'b0 || got_hab !== 8'h00) begin
      n_fail++; $display("FAIL miss_resp got v %b hit %b fail %b hab %h want 1 0 0 00", got_valid, got_hit, got_fail, got_hab); end
    n_cmp++; if (got_ativo !== 8'hFF || got_ocup !== 4'd8) begin n_fail++; $display("FAIL miss_table got %h ocup %0d want FF ocup 8", got_ativo, got_ocup); end
    do_req(1'b0, 5'h15);
    n_cmp++; if (got_hit !== 1'b1 || got_idx !== 3'd5) begin n_fail++; $display("FAIL miss_lookup got hit %b idx %0d want 1 idx 5", got_hit, got_idx); end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    while (!req_ready_out) @(negedge clk);
    req_valid_in = 1'b1; req_op_in = 1'b0; req_endereco_in = 5'h06;
    @(posedge clk);
    #1 req_valid_in = 1'b0;
    @(negedge clk);
    flush_in = 1'b1;
    #1;
    n_cmp++; if (req_ready_out !== 1'b0) begin n_fail++; $display("FAIL flush_ready_low got %b want 0", req_ready_out); end
    @(negedge clk);
    n_cmp++; if (ocupacao_out !== 4'd0 || slot_ativo_out !== 8'h00) begin
      n_fail++; $display("FAIL flush_clear got ocup %0d ativo %h want 0 00", ocupacao_out, slot_ativo_out); end
    flush_in = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1 if (resp_valid_out) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_resp got %0d pulses want 0", seen); end
    n_cmp++; if (req_ready_out !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", req_ready_out); end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_req(1'b0, 5'h07);
    @(negedge clk);
    req_valid_in = 1'b1; req_op_in = 1'b0; req_endereco_in = 5'h08;
    @(posedge clk);
    #1 req_valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ocupacao_out !== 4'd0 || resp_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got ocup %0d valid %b want 0 0", ocupacao_out, resp_valid_out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1 if (resp_valid_out) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_resp got %0d pulses want 0", seen); end
    n_cmp++; if (req_ready_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", req_ready_out); end
    do_req(1'b0, 5'h09);
    n_cmp++; if (got_idx !== 3'd0 || got_hit !== 1'b0 || got_ocup !== 4'd1) begin
      n_fail++; $display("FAIL rstmid_alloc got idx %0d hit %b ocup %0d want 0 0 1", got_idx, got_hit, got_ocup); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 5'h0B);
    n_cmp++; if (got_idx !== 3'd1 || lat !== 2) begin n_fail++; $display("FAIL b2b_first got idx %0d lat %0d want 1 2", got_idx, lat); end
    do_req(1'b0, 5'h0C);
    n_cmp++; if (got_idx !== 3'd2 || got_ocup !== 4'd3) begin n_fail++; $display("FAIL b2b_second got idx %0d ocup %0d want 2 3", got_idx, got_ocup); end
  endtask

`ifdef GERENCIADOR_SLOTS_AGING_EN
  task automatic test_aging();
    int n;
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    do_req(1'b0, 5'h02);
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (expirou_valid_out) begin n = c; break; end
    end
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL aging_delay got %0d want 16", n); end
    n_cmp++; if (expirou_idx_out !== 3'd0 || slot_ativo_out[0] !== 1'b0 || ocupacao_out !== 4'd0) begin
      n_fail++; $display("FAIL aging_expire got idx %0d ativo %h ocup %0d want 0 00 0", expirou_idx_out, slot_ativo_out, ocupacao_out); end
    do_req(1'b0, 5'h02);
    repeat (10) @(negedge clk);
    do_req(1'b0, 5'h02);
    n_cmp++; if (got_hit !== 1'b1) begin n_fail++; $display("FAIL aging_hit got %b want 1", got_hit); end
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (expirou_valid_out) begin n = c; break; end
    end
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL aging_refresh got %0d want 16", n); end
  endtask
`endif

  initial begin
    test_reset();
    test_atualizar_alloc();
    test_hit_release();
    test_full();
    test_desativar_miss();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef GERENCIADOR_SLOTS_AGING_EN
    test_aging();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
